// File: rtl/dec_fun.sv
// Debounced request decoder: accepts a word stable for STABLE_CYC valid cycles and holds it HOLD_CYC cycles.
// Optional saturating error counter on out_ERRCNT when DEC_FUN_ERR_CNT_EN is defined.
module dec_fun #(
  parameter int unsigned STABLE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_CODE,
  input  logic       in_7SEG,
  input  logic       in_INTERF,
  input  logic       in_VALID,
  output logic       out_A,
  output logic       out_B,
  output logic       out_C,
  output logic       out_INTERF,
  output logic       out_VALID,
  output logic       out_BUSY,
  output logic       out_ERR
`ifdef DEC_FUN_ERR_CNT_EN
  ,
  output logic [7:0] out_ERRCNT
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    HOLD
  } state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [3:0] match_cnt;
  logic [7:0] hold_cnt;
  logic [4:0] cand;

  logic [4:0] w;
  logic       w_null;
  logic       w_legal;
  logic       w_same;
  logic       err_det;

  assign w      = {in_INTERF, in_7SEG, in_CODE};
  assign w_null = !in_7SEG && (in_CODE == 3'b000);
  assign w_same = (w == cand);

  // B alone is carried by in_7SEG, so a bare code 010 is malformed
  always_comb begin
    w_legal = 1'b0;
    if (in_7SEG)
      w_legal = (in_CODE == 3'b000);
    else
      w_legal = (in_CODE != 3'b000) && (in_CODE != 3'b010);
  end

  assign err_det  = (state == IDLE) && in_VALID
                    && !w_null && !w_legal;
  assign out_BUSY = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      match_cnt  <= 4'd0;
      hold_cnt   <= 8'd0;
      cand       <= 5'd0;
      out_A      <= 1'b0;
      out_B      <= 1'b0;
      out_C      <= 1'b0;
      out_INTERF <= 1'b0;
      out_VALID  <= 1'b0;
      out_ERR    <= 1'b0;
    end else begin
      out_VALID <= 1'b0;
      out_ERR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_VALID && !w_null) begin
            if (w_legal) begin
              cand      <= w;
              match_cnt <= 4'd1;
              state     <= CHECK;
            end else begin
              out_ERR <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (in_VALID) begin
            if (!w_same) begin
              match_cnt <= 4'd0;
              state     <= IDLE;
            end else if (match_cnt == STABLE_LAST) begin
              out_A      <= cand[0];
              out_B      <= cand[1] | cand[3];
              out_C      <= cand[2];
              out_INTERF <= cand[4];
              out_VALID  <= 1'b1;
              match_cnt  <= 4'd0;
              hold_cnt   <= HOLD_LAST;
              state      <= HOLD;
            end else begin
              match_cnt <= match_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          // the out_VALID cycle is the first of the hold window
          if (hold_cnt == 8'd0) begin
            out_A      <= 1'b0;
            out_B      <= 1'b0;
            out_C      <= 1'b0;
            out_INTERF <= 1'b0;
            state      <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEC_FUN_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      out_ERRCNT <= 8'd0;
    else if (err_det && (out_ERRCNT != 8'hFF))
      out_ERRCNT <= out_ERRCNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dec_fun.sv
// Scoreboard bench for dec_fun: directed words, monitor pops expected events.
// Exercises DEC_FUN_ERR_CNT_EN checks when that macro is defined.
module tb_dec_fun;

  logic       clk;
  logic       rst;
  logic [2:0] in_CODE;
  logic       in_7SEG;
  logic       in_INTERF;
  logic       in_VALID;
  logic       out_A;
  logic       out_B;
  logic       out_C;
  logic       out_INTERF;
  logic       out_VALID;
  logic       out_BUSY;
  logic       out_ERR;
`ifdef DEC_FUN_ERR_CNT_EN
  logic [7:0] out_ERRCNT;
`endif

  typedef struct {
    bit err;
    bit a;
    bit b;
    bit c;
    bit i;
  } exp_t;

  exp_t q[$];
  int   n_run;
  int   n_fail;

  dec_fun #(.STABLE_CYC(3), .HOLD_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_CODE   (in_CODE),
    .in_7SEG   (in_7SEG),
    .in_INTERF (in_INTERF),
    .in_VALID  (in_VALID),
    .out_A     (out_A),
    .out_B     (out_B),
    .out_C     (out_C),
    .out_INTERF(out_INTERF),
    .out_VALID (out_VALID),
    .out_BUSY  (out_BUSY),
    .out_ERR   (out_ERR)
`ifdef DEC_FUN_ERR_CNT_EN
    ,
    .out_ERRCNT(out_ERRCNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // one cycle: apply inputs, step past the edge
  task automatic drive(input logic v, input logic [4:0] w);
    in_VALID  = v;
    in_INTERF = w[4];
    in_7SEG   = w[3];
    in_CODE   = w[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd0);
  endtask

  task automatic push_ok(input bit a, input bit b, input bit c,
                         input bit i);
    exp_t e;
    e.err = 1'b0; e.a = a; e.b = b; e.c = c; e.i = i;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.a = 1'b0; e.b = 1'b0; e.c = 1'b0; e.i = 1'b0;
    q.push_back(e);
  endtask

  // monitor: every out_VALID/out_ERR must match the next queued event
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (out_VALID || out_ERR)) begin
      n_run++;
      if (out_VALID && out_ERR) begin
        n_fail++;
        $display("FAIL both_pulses: valid=1 err=1, expected one");
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b err=%0b, expected none",
                 out_VALID, out_ERR);
      end else begin
        e = q.pop_front();
        if (out_ERR != e.err ||
            (!e.err && {out_A, out_B, out_C, out_INTERF} !=
                       {e.a, e.b, e.c, e.i})) begin
          n_fail++;
          $display("FAIL event: got err=%0b abci=%b%b%b%b, expected err=%0b abci=%b%b%b%b",
                   out_ERR, out_A, out_B, out_C, out_INTERF,
                   e.err, e.a, e.b, e.c, e.i);
        end
      end
    end
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b1, 5'b00001);
    drive(1'b0, 5'd0);
    rst = 1'b0;
    chk("reset_outs", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'd0);
    chk("reset_busy", {7'd0, out_BUSY}, 8'd0);
    chk("reset_pulses", {6'd0, out_VALID, out_ERR}, 8'd0);
`ifdef DEC_FUN_ERR_CNT_EN
    chk("reset_errcnt", out_ERRCNT, 8'd0);
`endif

    // A accepted after 3 cycles, held 16
    push_ok(1, 0, 0, 0);
    repeat (3) drive(1'b1, 5'b00001);
    chk("t1_valid_c3", {7'd0, out_VALID}, 8'd1);
    chk("t1_busy_c3", {7'd0, out_BUSY}, 8'd1);
    idle(15);
    chk("t1_hold_c18", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'h8);
    idle(1);
    chk("t1_clear_c19", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'd0);
    chk("t1_busy_c19", {7'd0, out_BUSY}, 8'd0);

    // B alone on matrix, accepted right at the end of the previous hold
    push_ok(0, 1, 0, 1);
    repeat (3) drive(1'b1, 5'b11000);
    chk("t2_outs", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'h5);
    // words during HOLD are ignored, even illegal ones
    repeat (4) drive(1'b1, 5'b00010);
    chk("t2_hold_ignore", {7'd0, out_ERR}, 8'd0);
    idle(12);
    chk("t2_idle", {7'd0, out_BUSY}, 8'd0);

    // illegal 010 in IDLE
    push_err();
    drive(1'b1, 5'b00010);
    chk("t3_err", {7'd0, out_ERR}, 8'd1);
    chk("t3_busy", {7'd0, out_BUSY}, 8'd0);
`ifdef DEC_FUN_ERR_CNT_EN
    chk("t3_errcnt", out_ERRCNT, 8'd1);
`endif
    drive(1'b0, 5'd0);
    chk("t3_err_once", {7'd0, out_ERR}, 8'd0);

    // gaps in in_VALID hold the match count
    push_ok(1, 1, 1, 0);
    repeat (2) drive(1'b1, 5'b00111);
    idle(3);
    chk("t4_busy_gap", {7'd0, out_BUSY}, 8'd1);
    chk("t4_no_early", {7'd0, out_VALID}, 8'd0);
    drive(1'b1, 5'b00111);
    chk("t4_valid", {7'd0, out_VALID}, 8'd1);
    idle(16);
    chk("t4_idle", {7'd0, out_BUSY}, 8'd0);

    // mismatch aborts and the new word is not re-evaluated
    drive(1'b1, 5'b00011);
    drive(1'b1, 5'b00110);
    chk("t5_busy", {7'd0, out_BUSY}, 8'd0);
    chk("t5_pulses", {6'd0, out_VALID, out_ERR}, 8'd0);
    idle(3);

    // reset in HOLD, with in_VALID high on the reset cycle
    push_ok(0, 0, 1, 0);
    repeat (3) drive(1'b1, 5'b00100);
    idle(5);
    chk("t6_held", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'h2);
    rst = 1'b1;
    drive(1'b1, 5'b00001);
    rst = 1'b0;
    chk("t6_rst_outs", {4'd0, out_A, out_B, out_C, out_INTERF}, 8'd0);
    chk("t6_rst_busy", {7'd0, out_BUSY}, 8'd0);
    chk("t6_rst_pulses", {6'd0, out_VALID, out_ERR}, 8'd0);
    idle(2);
    chk("t6_after_rst", {7'd0, out_BUSY}, 8'd0);

`ifdef DEC_FUN_ERR_CNT_EN
    for (int k = 0; k < 300; k++) begin
      push_err();
      drive(1'b1, 5'b01001);
    end
    idle(2);
    chk("t7_errcnt_sat", out_ERRCNT, 8'd255);
`endif

    idle(3);
    chk("pending_events", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
